// File: rtl/bsg_mem_gran_pkg.sv
// Shared types and helpers for the granular-mask banked SRAM.
package bsg_mem_gran_pkg;

    typedef enum logic {eInit, eReady} state_e;

    function automatic int mask_width(input int data_w, input int gran);
        return data_w / gran;
    endfunction

    // clog2 that never returns 0, so single-element structures still get a 1-bit index
    function automatic int safe_clog2(input int x);
        return (x <= 1) ? 1 : $clog2(x);
    endfunction

endpackage

// File: rtl/bsg_fifo_1r1w_small.sv
// Small circular-buffer FIFO with valid/ready input and valid/yumi output.
module bsg_fifo_1r1w_small
    import bsg_mem_gran_pkg::*;
#(
    parameter int width_p = 32,
    parameter int els_p = 2
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               v_i,
    output logic               ready_o,
    input  logic [width_p-1:0] data_i,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);

    localparam int ptr_width_lp = safe_clog2(els_p);
    localparam int cnt_width_lp = $clog2(els_p + 1);

    logic [width_p-1:0]      mem [els_p];
    logic [ptr_width_lp-1:0] rd_ptr_r, wr_ptr_r;
    logic [cnt_width_lp-1:0] count_r;
    logic                    enq;

    function automatic logic [ptr_width_lp-1:0] ptr_inc(input logic [ptr_width_lp-1:0] p);
        return (p == ptr_width_lp'(els_p - 1)) ? '0 : p + ptr_width_lp'(1);
    endfunction

    assign ready_o = (count_r != cnt_width_lp'(els_p));
    assign v_o     = (count_r != '0);
    assign data_o  = mem[rd_ptr_r];
    assign enq     = v_i & ready_o;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (enq) wr_ptr_r <= ptr_inc(wr_ptr_r);
            if (yumi_i) rd_ptr_r <= ptr_inc(rd_ptr_r);
            count_r <= count_r + cnt_width_lp'(enq) - cnt_width_lp'(yumi_i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (enq) mem[wr_ptr_r] <= data_i;
    end

endmodule

// File: rtl/bsg_mem_1rw_sync_mask_write_bit.sv
// Behavioural 1RW synchronous SRAM with a per-bit write mask; stand-in for a hardened macro.
module bsg_mem_1rw_sync_mask_write_bit
    import bsg_mem_gran_pkg::*;
#(
    parameter int width_p = 32,
    parameter int els_p = 16,
    localparam int addr_width_lp = safe_clog2(els_p)
) (
    input  logic                     clk_i,
    input  logic                     v_i,
    input  logic                     w_i,
    input  logic [addr_width_lp-1:0] addr_i,
    input  logic [width_p-1:0]       data_i,
    input  logic [width_p-1:0]       w_mask_i,
    output logic [width_p-1:0]       data_o
);

    logic [width_p-1:0] mem [els_p];

    always_ff @(posedge clk_i) begin
        if (v_i) begin
            if (w_i) begin
                mem[addr_i] <= (mem[addr_i] & ~w_mask_i) | (data_i & w_mask_i);
            end else begin
                data_o <= mem[addr_i];
            end
        end
    end

endmodule

// File: rtl/bsg_mem_1rw_sync_mask_write_gran_bank.sv
// One SRAM bank: widens the granular write mask to a per-bit mask.
module bsg_mem_1rw_sync_mask_write_gran_bank
    import bsg_mem_gran_pkg::*;
#(
    parameter int width_p = 32,
    parameter int els_p = 16,
    parameter int mask_gran_p = 8,
    localparam int addr_width_lp = safe_clog2(els_p),
    localparam int mask_width_lp = mask_width(width_p, mask_gran_p)
) (
    input  logic                     clk_i,
    input  logic                     v_i,
    input  logic                     w_i,
    input  logic [addr_width_lp-1:0] addr_i,
    input  logic [width_p-1:0]       data_i,
    input  logic [mask_width_lp-1:0] w_mask_i,
    output logic [width_p-1:0]       data_o
);

    logic [width_p-1:0] bit_mask;

    always_comb begin
        bit_mask = '0;
        for (int k = 0; k < mask_width_lp; k++) begin
            bit_mask[k*mask_gran_p +: mask_gran_p] = {mask_gran_p{w_mask_i[k]}};
        end
    end

    bsg_mem_1rw_sync_mask_write_bit #(
        .width_p(width_p),
        .els_p  (els_p)
    ) mem (
        .clk_i   (clk_i),
        .v_i     (v_i),
        .w_i     (w_i),
        .addr_i  (addr_i),
        .data_i  (data_i),
        .w_mask_i(bit_mask),
        .data_o  (data_o)
    );

endmodule

// File: rtl/bsg_mem_1rw_sync_mask_write_gran_pipe.sv
// Banked, pipelined 1RW SRAM with granular write mask and credit-managed read-data buffer.
// Optional BSG_MEM_1RW_SYNC_MASK_WRITE_GRAN_ZERO_INIT_EN zero-fills all banks after reset.
//
// state  | meaning
// eInit  | post-reset; requests blocked (zero-fill sweep when enabled)
// eReady | accepting requests while read credits remain
module bsg_mem_1rw_sync_mask_write_gran_pipe
    import bsg_mem_gran_pkg::*;
#(
    parameter int els_p = 64,
    parameter int data_width_p = 32,
    parameter int mask_gran_p = 8,
    parameter int num_banks_p = 1,
    parameter int pipeline_p = 0,
    parameter int out_els_p = 2,
    localparam int addr_width_lp = safe_clog2(els_p),
    localparam int mask_width_lp = mask_width(data_width_p, mask_gran_p)
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     v_i,
    input  logic                     w_i,
    input  logic [addr_width_lp-1:0] addr_i,
    input  logic [data_width_p-1:0]  data_i,
    input  logic [mask_width_lp-1:0] w_mask_i,
    output logic                     ready_o,
    output logic                     v_o,
    output logic [data_width_p-1:0]  data_o,
    input  logic                     yumi_i
);

    localparam int bank_bits_lp       = $clog2(num_banks_p);
    localparam int bank_sel_width_lp  = safe_clog2(num_banks_p);
    localparam int rows_lp            = els_p / num_banks_p;
    localparam int row_width_lp       = safe_clog2(rows_lp);
    localparam int credit_width_lp    = $clog2(out_els_p + 1);

    state_e                       state_r, state_n;
    logic [credit_width_lp-1:0]   credits_r;
    logic                         accept, rd_accept, init_active;
    logic [bank_sel_width_lp-1:0] bank_sel;
    logic [row_width_lp-1:0]      row_addr, bank_addr;
    logic [data_width_p-1:0]      bank_wdata;
    logic [mask_width_lp-1:0]     bank_wmask;
    logic [data_width_p-1:0]      bank_data [num_banks_p];

    if (num_banks_p == 1) begin : g_one_bank
        assign bank_sel = '0;
        assign row_addr = addr_i;
    end else begin : g_multi_bank
        assign bank_sel = addr_i[bank_bits_lp-1:0];
        assign row_addr = addr_i[addr_width_lp-1:bank_bits_lp];
    end

    assign ready_o   = (state_r == eReady) && (credits_r != '0);
    assign accept    = v_i & ready_o;
    assign rd_accept = accept & ~w_i;

`ifdef BSG_MEM_1RW_SYNC_MASK_WRITE_GRAN_ZERO_INIT_EN
    logic [row_width_lp-1:0] init_row_r, init_row_n;

    assign init_active = (state_r == eInit);

    always_comb begin
        state_n    = state_r;
        init_row_n = init_row_r;
        case (state_r)
            eInit: begin
                init_row_n = init_row_r + row_width_lp'(1);
                if (init_row_r == row_width_lp'(rows_lp - 1)) state_n = eReady;
            end
            default: state_n = eReady;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) init_row_r <= '0;
        else         init_row_r <= init_row_n;
    end
`else
    assign init_active = 1'b0;

    always_comb begin
        state_n = eReady;
    end
`endif

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r   <= eInit;
            credits_r <= credit_width_lp'(out_els_p);
        end else begin
            state_r   <= state_n;
            credits_r <= credits_r - credit_width_lp'(rd_accept) + credit_width_lp'(yumi_i);
        end
    end

    // The zero-fill sweep drives every bank at once with a full mask
    always_comb begin
        bank_addr  = row_addr;
        bank_wdata = data_i;
        bank_wmask = w_mask_i;
`ifdef BSG_MEM_1RW_SYNC_MASK_WRITE_GRAN_ZERO_INIT_EN
        if (init_active) begin
            bank_addr  = init_row_r;
            bank_wdata = '0;
            bank_wmask = '1;
        end
`endif
    end

    for (genvar b = 0; b < num_banks_p; b++) begin : g_bank
        logic sel;
        assign sel = (bank_sel == bank_sel_width_lp'(b));

        bsg_mem_1rw_sync_mask_write_gran_bank #(
            .width_p    (data_width_p),
            .els_p      (rows_lp),
            .mask_gran_p(mask_gran_p)
        ) bank (
            .clk_i   (clk_i),
            .v_i     (init_active | (accept & sel)),
            .w_i     (init_active | w_i),
            .addr_i  (bank_addr),
            .data_i  (bank_wdata),
            .w_mask_i(bank_wmask),
            .data_o  (bank_data[b])
        );
    end

    logic                         rd_v_r;
    logic [bank_sel_width_lp-1:0] rd_bank_r;
    logic [data_width_p-1:0]      mux_data, ret_data;
    logic                         ret_v;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rd_v_r    <= 1'b0;
            rd_bank_r <= '0;
        end else begin
            rd_v_r    <= rd_accept;
            rd_bank_r <= bank_sel;
        end
    end

    assign mux_data = bank_data[rd_bank_r];

    if (pipeline_p != 0) begin : g_pipe
        logic                    v_r;
        logic [data_width_p-1:0] d_r;

        always_ff @(posedge clk_i) begin
            if (reset_i) begin
                v_r <= 1'b0;
                d_r <= '0;
            end else begin
                v_r <= rd_v_r;
                d_r <= mux_data;
            end
        end

        assign ret_v    = v_r;
        assign ret_data = d_r;
    end else begin : g_no_pipe
        assign ret_v    = rd_v_r;
        assign ret_data = mux_data;
    end

    // Returning data bypasses an empty buffer so v_o rises the cycle it arrives
    logic                    fifo_v, fifo_ready, fifo_enq;
    logic [data_width_p-1:0] fifo_data;

    assign fifo_enq = ret_v & ~(~fifo_v & yumi_i);
    assign v_o      = fifo_v | ret_v;
    assign data_o   = fifo_v ? fifo_data : (ret_v ? ret_data : '0);

    bsg_fifo_1r1w_small #(
        .width_p(data_width_p),
        .els_p  (out_els_p)
    ) out_fifo (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .v_i    (fifo_enq),
        .ready_o(fifo_ready),
        .data_i (ret_data),
        .v_o    (fifo_v),
        .data_o (fifo_data),
        .yumi_i (yumi_i & fifo_v)
    );

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        assert (data_width_p % mask_gran_p == 0);
        assert (els_p % num_banks_p == 0);
        if (!reset_i) begin
            assert (!yumi_i || v_o);
            assert (!$isunknown({v_i, w_i, addr_i}));
            assert (!fifo_enq || fifo_ready);
        end
    end
`endif

endmodule
